// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the bit-counter width helper.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One spare bit over $clog2 so the counter can never wrap, and so that
    // WIDTH=1 still gets a 1-bit counter.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the serial adder: the requester drives operands
// and start, the adder returns status and the registered result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/dataflow_fulladder.sv
// 1-bit dataflow full adder, used as the time-multiplexed bit slice.
module dataflow_fulladder (
    input  logic first,
    input  logic second,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = first ^ second ^ cin;
    assign cout = (first & second) | (cin & (first ^ second));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: captures operands on start, adds one bit pair
// per cycle LSB-first through a single full adder, then pulses done with the
// registered sum and carry-out.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum, fa_cout;
    logic [WIDTH:0]   acc_ext;

    dataflow_fulladder u_fa (
        .first  (sh_a_q[0]),
        .second (sh_b_q[0]),
        .cin    (carry_q),
        .sum    (fa_sum),
        .cout   (fa_cout)
    );

    // New sum bit enters at the MSB; taking the upper WIDTH bits of the
    // extended vector stays legal when WIDTH=1.
    assign acc_ext = {fa_sum, acc_q};

    // Status is decoded from the state register alone, so it is glitch-free.
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    // Next-state and datapath update; everything holds unless stated.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    sh_a_d  = bus.a;
                    sh_b_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                acc_d   = acc_ext[WIDTH:1];
                carry_d = fa_cout;
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    sum_d   = acc_ext[WIDTH:1];
                    cout_d  = fa_cout;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
